// File: rtl/cplx_pkg.sv
// Shared types and widths for the sequential complex multiplier.
// Operand width is fixed at 16 because the add/sub stage is the 32-bit cla32.
package cplx_pkg;

   localparam int W  = 16;
   localparam int PW = 2 * W;
   localparam int RW = 2 * W + 1;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      MUL0 = 3'd1,
      MUL1 = 3'd2,
      MUL2 = 3'd3,
      MUL3 = 3'd4,
      DONE = 3'd5
   } state_t;

endpackage

// File: rtl/cla32.sv
// 32-bit carry-lookahead adder: 4-bit lookahead groups chained on group generate/propagate.
module cla32 (
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        cin,
   output logic [31:0] sum,
   output logic        cout
);

   logic [31:0] g;
   logic [31:0] p;
   logic [32:0] c;
   logic [7:0]  gg;
   logic [7:0]  gp;

   assign g = a & b;
   assign p = a ^ b;

   always_comb begin
      c    = '0;
      gg   = '0;
      gp   = '0;
      c[0] = cin;
      for (int i = 0; i < 8; i++) begin
         int k;
         k = 4 * i;
         gg[i] = g[k+3] | (p[k+3] & g[k+2]) | (p[k+3] & p[k+2] & g[k+1])
               | (p[k+3] & p[k+2] & p[k+1] & g[k]);
         gp[i] = &p[k +: 4];
         c[k+1] = g[k] | (p[k] & c[k]);
         c[k+2] = g[k+1] | (p[k+1] & g[k]) | (p[k+1] & p[k] & c[k]);
         c[k+3] = g[k+2] | (p[k+2] & g[k+1]) | (p[k+2] & p[k+1] & g[k])
                | (p[k+2] & p[k+1] & p[k] & c[k]);
         c[k+4] = gg[i] | (gp[i] & c[k]);
      end
   end

   assign sum  = p ^ c[31:0];
   assign cout = c[32];

endmodule

// File: rtl/smul16.sv
// Combinational W x W signed multiplier; the single multiplier shared by all four partial products.
module smul16
   import cplx_pkg::*;
(
   input  logic signed [W-1:0]  a,
   input  logic signed [W-1:0]  b,
   output logic signed [PW-1:0] p
);

   assign p = PW'(a) * PW'(b);

endmodule

// File: rtl/cplx_mul_seq.sv
// Sequential complex multiplier: one shared signed multiplier and one cla32 add/sub,
// time-multiplexed over four cycles, with valid/ready on both sides.
module cplx_mul_seq #(
   parameter int W = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic signed [W-1:0] a_re,
   input  logic signed [W-1:0] a_im,
   input  logic signed [W-1:0] b_re,
   input  logic signed [W-1:0] b_im,
   output logic                out_valid,
   input  logic                out_ready,
   output logic signed [2*W:0] p_re,
   output logic signed [2*W:0] p_im,
   output logic                busy
);

   import cplx_pkg::*;

   state_t state;

   logic signed [W-1:0]  opa_re;
   logic signed [W-1:0]  opa_im;
   logic signed [W-1:0]  opb_re;
   logic signed [W-1:0]  opb_im;
   logic signed [RW-1:0] acc_re;
   logic signed [RW-1:0] acc_im;

   logic signed [W-1:0]  mx;
   logic signed [W-1:0]  my;
   logic signed [PW-1:0] prod;
   logic                 sub;
   logic [PW-1:0]        add_a;
   logic [PW-1:0]        add_b;
   logic [PW-1:0]        add_sum;
   logic                 add_cout;
   logic signed [RW-1:0] add_res;

   function automatic logic signed [RW-1:0] sext_prod(input logic signed [PW-1:0] x);
      return {x[PW-1], x};
   endfunction

   // Treating both adder inputs as sign-extended makes the extra bit exact for any operands.
   function automatic logic ext_msb(input logic a_msb, input logic b_msb, input logic co);
      return a_msb ^ b_msb ^ co;
   endfunction

   assign in_ready = rst_n & (state == IDLE);
   assign busy     = rst_n & (state != IDLE);

   always_comb begin
      mx = opa_re;
      my = opb_re;
      case (state)
         MUL1:    begin mx = opa_im; my = opb_im; end
         MUL2:    begin mx = opa_re; my = opb_im; end
         MUL3:    begin mx = opa_im; my = opb_re; end
         default: begin mx = opa_re; my = opb_re; end
      endcase
   end

   smul16 u_mul (
      .a (mx),
      .b (my),
      .p (prod)
   );

   assign sub   = (state == MUL1);
   assign add_a = sub ? acc_re[PW-1:0] : acc_im[PW-1:0];
   assign add_b = sub ? ~prod : prod;

   cla32 u_add (
      .a    (add_a),
      .b    (add_b),
      .cin  (sub),
      .sum  (add_sum),
      .cout (add_cout)
   );

   assign add_res = {ext_msb(add_a[PW-1], add_b[PW-1], add_cout), add_sum};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         out_valid <= 1'b0;
         p_re      <= '0;
         p_im      <= '0;
         acc_re    <= '0;
         acc_im    <= '0;
         opa_re    <= '0;
         opa_im    <= '0;
         opb_re    <= '0;
         opb_im    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  opa_re <= a_re;
                  opa_im <= a_im;
                  opb_re <= b_re;
                  opb_im <= b_im;
                  state  <= MUL0;
               end
            end
            MUL0: begin
               acc_re <= sext_prod(prod);
               state  <= MUL1;
            end
            MUL1: begin
               p_re  <= add_res;
               state <= MUL2;
            end
            MUL2: begin
               acc_im <= sext_prod(prod);
               state  <= MUL3;
            end
            MUL3: begin
               p_im      <= add_res;
               out_valid <= 1'b1;
               state     <= DONE;
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cplx_mul_seq.sv
// Directed and randomized-stream bench for cplx_mul_seq.
module tb_cplx_mul_seq;

   localparam int W = 16;

   logic                clk = 1'b0;
   logic                rst_n;
   logic                in_valid;
   logic                in_ready;
   logic signed [W-1:0] a_re;
   logic signed [W-1:0] a_im;
   logic signed [W-1:0] b_re;
   logic signed [W-1:0] b_im;
   logic                out_valid;
   logic                out_ready;
   logic signed [2*W:0] p_re;
   logic signed [2*W:0] p_im;
   logic                busy;

   int     n_checks = 0;
   int     n_fail   = 0;
   int     n_rx     = 0;
   bit     mon_en   = 1'b0;
   longint q_re[$];
   longint q_im[$];

   always #5 clk = ~clk;

   cplx_mul_seq #(.W(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a_re      (a_re),
      .a_im      (a_im),
      .b_re      (b_re),
      .b_im      (b_im),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .p_re      (p_re),
      .p_im      (p_im),
      .busy      (busy)
   );

   task automatic check(input string tag, input longint obs, input longint exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(output int lat);
      lat = 0;
      while (!out_valid && lat < 20) begin
         step();
         lat++;
      end
   endtask

   task automatic start_op(input int ar, input int ai, input int br, input int bi);
      a_re     = 16'(ar);
      a_im     = 16'(ai);
      b_re     = 16'(br);
      b_im     = 16'(bi);
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
   endtask

   task automatic run_directed(input string tag, input int ar, input int ai, input int br,
                               input int bi, input longint er, input longint ei);
      int lat;
      check({tag, "_ready"}, in_ready, 1);
      start_op(ar, ai, br, bi);
      wait_valid(lat);
      check({tag, "_lat"}, lat, 4);
      check({tag, "_re"}, p_re, er);
      check({tag, "_im"}, p_im, ei);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check({tag, "_drop"}, out_valid, 0);
      check({tag, "_idle"}, busy, 0);
   endtask

   // Scoreboard for the random stream: handshakes are seen at the negedge before the edge.
   always @(negedge clk) begin
      if (mon_en) begin
         if (in_valid && in_ready) begin
            q_re.push_back(longint'(a_re) * longint'(b_re) - longint'(a_im) * longint'(b_im));
            q_im.push_back(longint'(a_re) * longint'(b_im) + longint'(a_im) * longint'(b_re));
         end
         if (out_valid && out_ready) begin
            check("stream_pending", q_re.size() > 0, 1);
            if (q_re.size() > 0) begin
               check("stream_re", p_re, q_re.pop_front());
               check("stream_im", p_im, q_im.pop_front());
            end
            n_rx++;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int  lat;
      bit  stable;
      bit  rdy_low;
      bit  seen;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a_re      = '0;
      a_im      = '0;
      b_re      = '0;
      b_im      = '0;
      step();
      step();
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_p_re", p_re, 0);
      check("rst_p_im", p_im, 0);
      in_valid = 1'b1;
      step();
      check("rst_no_accept", busy, 0);
      in_valid = 1'b0;
      rst_n    = 1'b1;
      step();

      run_directed("basic", 3, 4, 5, 6, -9, 38);
      run_directed("ext", -32768, -32768, -32768, -32768, 0, 64'sd2147483648);
      check("ext_bit32", p_im[32], 0);
      run_directed("mixed", -32768, 32767, 32767, -32768, 0, 64'sd2147418113);

      start_op(1, 2, 3, 4);
      wait_valid(lat);
      check("bp_lat", lat, 4);
      check("bp_re", p_re, -5);
      check("bp_im", p_im, 10);
      a_re     = 16'sd7;
      a_im     = -16'sd2;
      b_re     = -16'sd3;
      b_im     = 16'sd5;
      in_valid = 1'b1;
      stable   = 1'b1;
      rdy_low  = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         if (longint'(p_re) != -5 || longint'(p_im) != 10 || !out_valid) stable = 1'b0;
         if (in_ready) rdy_low = 1'b0;
      end
      check("bp_stable", stable, 1);
      check("bp_in_ready_low", rdy_low, 1);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("bp_hs_drop", out_valid, 0);
      check("bp_idle_ready", in_ready, 1);
      step();
      in_valid = 1'b0;
      check("bp_accept", busy, 1);
      wait_valid(lat);
      check("bp2_lat", lat, 4);
      check("bp2_re", p_re, -11);
      check("bp2_im", p_im, 41);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;

      start_op(9, -4, 6, 2);
      step();
      step();
      rst_n = 1'b0;
      check("rmo_in_ready", in_ready, 0);
      step();
      rst_n = 1'b1;
      check("rmo_busy", busy, 0);
      check("rmo_out_valid", out_valid, 0);
      check("rmo_p_re", p_re, 0);
      check("rmo_p_im", p_im, 0);
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         step();
         if (out_valid) seen = 1'b1;
      end
      check("rmo_no_pulse", seen, 0);
      run_directed("post_rst", -100, 50, 20, -7, -1650, 1700);

      mon_en = 1'b1;
      fork
         begin
            for (int i = 0; i < 50; i++) begin
               int  guard;
               bit  hs;
               repeat ($urandom_range(0, 3)) step();
               a_re     = 16'($urandom);
               a_im     = 16'($urandom);
               b_re     = 16'($urandom);
               b_im     = 16'($urandom);
               in_valid = 1'b1;
               guard    = 0;
               hs       = 1'b0;
               while (!hs && guard < 200) begin
                  @(negedge clk);
                  hs = in_ready;
                  @(posedge clk);
                  #1;
                  guard++;
               end
               in_valid = 1'b0;
            end
         end
         begin
            int cyc;
            cyc = 0;
            while (n_rx < 50 && cyc < 3000) begin
               out_ready = 1'($urandom_range(0, 1));
               step();
               cyc++;
            end
            out_ready = 1'b0;
         end
      join
      mon_en = 1'b0;
      check("stream_count", n_rx, 50);
      check("stream_leftover", q_re.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/cplx_mul_seq.md
Name: cplx_mul_seq

Overview:
- Sequential complex multiplier front end: computes (a_re + j·a_im)·(b_re + j·b_im) with one shared signed multiplier time-multiplexed over four cycles.
- Partial products feed the 32-bit carry-lookahead adder stage (cla32), used as an adder or subtractor, to form the real and imaginary results.
- Sits directly upstream of the adder stage and replaces four parallel multipliers in area-constrained builds.
- Valid/ready handshake on both input and output.

Parameters:
- W, 16, signed operand width. Datapath widths derive from W. Only W=16 is supported with cla32.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  operand set valid
- in_ready  out  1  block can accept an operand set
- a_re, a_im, b_re, b_im  in  W each  signed operands, two's complement
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- p_re  out  2W+1  signed real result
- p_im  out  2W+1  signed imaginary result
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (rst_n low at a clk edge):
  - state goes to IDLE; out_valid=0; p_re=p_im=0; internal accumulators and operand registers are cleared.
  - in_ready is forced low while rst_n is low.
- States and transitions:
  - IDLE: in_ready=1. On in_valid&in_ready, register all four operands and go to MUL0.
  - MUL0: acc_re <= a_re·b_re (sign-extended to 2W+1).
  - MUL1: p_re <= acc_re − a_im·b_im. Subtract is performed as adder(A, ~B) with cin=1.
  - MUL2: acc_im <= a_re·b_im.
  - MUL3: p_im <= acc_im + a_im·b_re. Go to DONE.
  - DONE: out_valid=1; p_re and p_im are held stable. On out_ready, go to IDLE and drop out_valid at that edge.
- Latency: handshake at edge E0 gives out_valid high after edge E4.
  - Minimum initiation interval is 6 cycles: E0 accept, E1–E4 compute, E5 output handshake, IDLE for one cycle.
  - There is no back-to-back acceptance: in_ready=0 in DONE.
- Width rule:
  - Products are 2W bits signed.
  - The adder works on 2W bits.
  - Result bit 2W = A[2W−1] ^ B'[2W−1] ^ cout, where B' is the possibly inverted operand. This gives an exact (2W+1)-bit signed result with no overflow for any input, including all operands = −2^(W−1).
- Operands are sampled only at the accepting edge. Input changes during MUL0..DONE are ignored.
- Backpressure: out_ready low in DONE holds every output bit stable indefinitely. in_valid is ignored during that time.
- Reset mid-operation (any state) aborts the operation: no out_valid pulse and no partial result on p_re/p_im.
- in_valid asserted together with reset release: not accepted on that edge. The earliest acceptance is the first edge with rst_n high while in IDLE.
- busy = (state != IDLE). busy=0 during reset.

Decomposition:
- Shared package cplx_pkg:
  - state enum IDLE, MUL0, MUL1, MUL2, MUL3, DONE (3-bit encoding)
  - constant W=16
  - derived widths PW=2W and RW=2W+1
- Sub-module smul16: combinational W×W signed multiplier producing a 2W-bit result, one instance.
- The add/sub uses one instance of cla32 with an operand-invert mux and cin select.
- The top level holds the FSM, operand registers, operand-select mux and result registers.

Test Plan:
- Basic: (3+4j)·(5+6j), then out_ready=1.
  - Required: out_valid high 4 cycles after acceptance; p_re=−9, p_im=38; out_valid low on the following cycle.
- Extremes: all operands −32768.
  - Required: p_re=0, p_im=+2147483648 (33-bit 0x0_8000_0000, bit 32 = 0).
- Mixed extremes: (−32768+32767j)·(32767−32768j).
  - Required: p_re=0, p_im=2147418113.
- Backpressure: out_ready=0 for 10 cycles after out_valid while in_valid=1 with new operands.
  - Required: p_re/p_im stable; in_ready=0; the new set is accepted only on the IDLE cycle after the output handshake.
- Reset mid-op: assert rst_n=0 for 1 edge in MUL2.
  - Required: next cycle state IDLE, out_valid=0, p_re=p_im=0; no out_valid pulse for the aborted set; a new operation completes correctly.
- Stream: 50 random operand sets with random in_valid/out_ready gaps.
  - Required: results match the reference model in order; no handshake is dropped or duplicated.
